mul_hash_pipe: RTL and testbench

//  Multi-lane, fully pipelined multiplicative hash for the pigasus SME front end.
//  - Per lane: hash = top NBITS of ((key & len_mask) * HASH_B) mod 2^64.
//  - Byte-mask length is a per-beat runtime input, not a synthesis-time parameter.
//  - Adds valid/ready flow control with global stall and a tag passthrough.
//  - Sits between the shift-or match stage and the hash-table lookup.

---
 rtl/hash_pkg.sv | 22 ++
 rtl/mul_hash_lane.sv | 87 ++++++++
 rtl/mul_hash_pipe.sv | 61 ++++++
 tb/tb_mul_hash_pipe.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/hash_pkg.sv
`default_nettype none
// ============================================================================
//  hash_pkg : shared multiplicative-hash constants and byte-mask helper
//  Rev 1.0
// ============================================================================
package hash_pkg;

  localparam logic [63:0] HASH_B   = 64'h0b4e0ef37bc32127;
  localparam int          HASH_LAT = 5;

  // Lengths above 8 naturally select all eight bytes.
  function automatic logic [63:0] len_to_mask(input logic [3:0] len);
    logic [63:0] m;
    m = '0;
    for (int b = 0; b < 8; b++) begin
      if (b < int'(len)) m[8*b +: 8] = 8'hFF;
    end
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mul_hash_lane.sv
`default_nettype none
// ============================================================================
//  mul_hash_lane : one lane of the 5-stage mask/multiply/slice hash datapath
//  Rev 1.0
// ============================================================================
module mul_hash_lane
  import hash_pkg::*;
#(
  parameter int NBITS = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [63:0]      key,
  input  logic [3:0]       len,
  output logic [NBITS-1:0] hash
);

  localparam logic [15:0] c_b0 = HASH_B[15:0];
  localparam logic [15:0] c_b1 = HASH_B[31:16];
  localparam logic [15:0] c_b2 = HASH_B[47:32];
  localparam logic [15:0] c_b3 = HASH_B[63:48];

  function automatic logic [31:0] mul_full(input logic [15:0] a, input logic [15:0] b);
    return {16'd0, a} * {16'd0, b};
  endfunction

  logic [63:0]        r_key;
  logic [15:0]        w_a [4];
  logic [31:0]        r_pl [6];   // full products, i+j <= 2
  logic [15:0]        r_ph [4];   // i+j == 3, only the low half survives mod 2^64
  logic [31:0]        r_d0;
  logic [32:0]        r_d1;
  logic [31:0]        r_d2;
  logic [15:0]        r_d3;
  logic [63:0]        r_lo;
  logic [63:0]        r_hi;
  logic [NBITS-1:0]   w_hash;
  logic [63-NBITS:0]  w_unused_lo;

  always_comb begin
    for (int i = 0; i < 4; i++) w_a[i] = r_key[16*i +: 16];
  end

  assign {w_hash, w_unused_lo} = r_lo + r_hi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key <= '0;
      for (int i = 0; i < 6; i++) r_pl[i] <= '0;
      for (int i = 0; i < 4; i++) r_ph[i] <= '0;
      r_d0  <= '0;
      r_d1  <= '0;
      r_d2  <= '0;
      r_d3  <= '0;
      r_lo  <= '0;
      r_hi  <= '0;
      hash  <= '0;
    end else if (en) begin
      r_key   <= key & len_to_mask(len);

      r_pl[0] <= mul_full(w_a[0], c_b0);
      r_pl[1] <= mul_full(w_a[0], c_b1);
      r_pl[2] <= mul_full(w_a[1], c_b0);
      r_pl[3] <= mul_full(w_a[0], c_b2);
      r_pl[4] <= mul_full(w_a[1], c_b1);
      r_pl[5] <= mul_full(w_a[2], c_b0);
      r_ph[0] <= w_a[0] * c_b3;
      r_ph[1] <= w_a[1] * c_b2;
      r_ph[2] <= w_a[2] * c_b1;
      r_ph[3] <= w_a[3] * c_b0;

      // Diagonal sums; each is later placed at bit 16*(i+j).
      r_d0    <= r_pl[0];
      r_d1    <= {1'b0, r_pl[1]} + {1'b0, r_pl[2]};
      r_d2    <= r_pl[3] + r_pl[4] + r_pl[5];
      r_d3    <= r_ph[0] + r_ph[1] + r_ph[2] + r_ph[3];

      r_lo    <= {32'd0, r_d0} + {15'd0, r_d1, 16'd0};
      r_hi    <= {r_d2, 32'd0} + {r_d3, 48'd0};

      hash    <= w_hash;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mul_hash_pipe.sv
`default_nettype none
// ============================================================================
//  mul_hash_pipe : multi-lane pipelined multiplicative hash with valid/ready
//  Rev 1.0
// ============================================================================
module mul_hash_pipe
  import hash_pkg::*;
#(
  parameter int NLANES = 4,
  parameter int NBITS  = 15,
  parameter int TAG_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NLANES*64-1:0]    in_key,
  input  logic [NLANES*4-1:0]     in_len,
  input  logic [TAG_W-1:0]        in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NLANES*NBITS-1:0] out_hash,
  output logic [TAG_W-1:0]        out_tag
);

  logic                w_en;
  logic [HASH_LAT-1:0] r_vld;
  logic [TAG_W-1:0]    r_tag [HASH_LAT];

  // One global stall: the whole pipe moves only when the output slot frees up.
  assign w_en      = out_ready | ~out_valid;
  assign in_ready  = w_en;
  assign out_valid = r_vld[HASH_LAT-1];
  assign out_tag   = r_tag[HASH_LAT-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      for (int i = 0; i < HASH_LAT; i++) r_tag[i] <= '0;
    end else if (w_en) begin
      r_vld    <= {r_vld[HASH_LAT-2:0], in_valid};
      r_tag[0] <= in_tag;
      for (int i = 1; i < HASH_LAT; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  for (genvar g = 0; g < NLANES; g++) begin : g_lane
    mul_hash_lane #(
      .NBITS(NBITS)
    ) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (w_en),
      .key  (in_key[64*g +: 64]),
      .len  (in_len[4*g +: 4]),
      .hash (out_hash[NBITS*g +: NBITS])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_mul_hash_pipe.sv
`default_nettype none
// ============================================================================
//  tb_mul_hash_pipe : randomized scoreboard bench for mul_hash_pipe
//  Rev 1.0
// ============================================================================
module tb_mul_hash_pipe;

  localparam int NL = 4;
  localparam int NB = 15;
  localparam int TW = 16;
  localparam logic [63:0] REF_B = 64'h0b4e0ef37bc32127;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [NL*64-1:0] in_key;
  logic [NL*4-1:0]  in_len;
  logic [TW-1:0]    in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [NL*NB-1:0] out_hash;
  logic [TW-1:0]    out_tag;

  mul_hash_pipe #(.NLANES(NL), .NBITS(NB), .TAG_W(TW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_key   (in_key),
    .in_len   (in_len),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_hash (out_hash),
    .out_tag  (out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NL*NB-1:0] h;
    logic [TW-1:0]    t;
  } exp_t;

  exp_t             sb[$];
  int               total = 0;
  int               bad   = 0;
  int               n_out = 0;
  logic             stalled_prev = 1'b0;
  logic [NL*NB-1:0] held_h;
  logic [TW-1:0]    held_t;

  // Reference: plain 64-bit multiply of the masked key, keep the top NB bits.
  function automatic logic [NB-1:0] ref_hash(input logic [63:0] key, input logic [3:0] len);
    logic [63:0] k;
    logic [63:0] p;
    int          n;
    n = (len > 4'd8) ? 8 : int'(len);
    k = key;
    if (n < 8) k = key & ((64'd1 << (8*n)) - 64'd1);
    p = k * REF_B;
    return p[63 -: NB];
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: sample at negedge, score handshakes, then step past the posedge.
  task automatic tick(output logic acc, output logic ov, output logic ir,
                      output logic [NL*NB-1:0] oh);
    exp_t e;
    @(negedge clk);
    acc = in_valid && in_ready;
    ov  = out_valid;
    ir  = in_ready;
    oh  = out_hash;
    if (stalled_prev) begin
      chk("hold_hash", 64'(out_hash), 64'(held_h));
      chk("hold_tag", 64'(out_tag), 64'(held_t));
    end
    stalled_prev = out_valid && !out_ready;
    held_h = out_hash;
    held_t = out_tag;
    if (out_valid && out_ready) begin
      n_out++;
      if (sb.size() == 0) begin
        chk("out_without_beat", {63'd0, out_valid}, 64'd0);
      end else begin
        e = sb.pop_front();
        for (int l = 0; l < NL; l++)
          chk("lane_hash", 64'(out_hash[NB*l +: NB]), 64'(e.h[NB*l +: NB]));
        chk("tag", 64'(out_tag), 64'(e.t));
      end
    end
    if (acc) begin
      e.t = in_tag;
      for (int l = 0; l < NL; l++)
        e.h[NB*l +: NB] = ref_hash(in_key[64*l +: 64], in_len[4*l +: 4]);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_beat();
    for (int l = 0; l < NL; l++) begin
      in_key[64*l +: 64] = {$urandom, $urandom};
      in_len[4*l +: 4]   = 4'($urandom_range(0, 15));
    end
    in_tag = TW'($urandom);
  endtask

  task automatic set_lane(input int l, input logic [63:0] k, input logic [3:0] n);
    in_key[64*l +: 64] = k;
    in_len[4*l +: 4]   = n;
  endtask

  initial begin
    logic             acc, ov, ir, pending;
    logic [NL*NB-1:0] oh;
    int               sent;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_key = '0; in_len = '0; in_tag = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_hash", 64'(out_hash), 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_rst", {63'd0, in_ready}, 64'd1);

    // Directed beats, latency and known constants.
    for (int k = 1; k <= 11; k++) begin
      in_valid = (k <= 5);
      if (k <= 5) begin
        rand_beat();
        case (k)
          1: set_lane(0, 64'd0, 4'd8);
          2: set_lane(0, 64'd1, 4'd8);
          3: set_lane(0, 64'hFFFF_FFFF_FFFF_FFFF, 4'd1);
          4: set_lane(0, 64'hFFFF_FFFF_FFFF_FFFF, 4'd0);
          default: begin
            set_lane(0, 64'h0123_4567_89AB_CDEF, 4'd8);
            set_lane(1, 64'hFEDC_BA98_7654_3210, 4'd3);
            set_lane(2, 64'hDEAD_BEEF_CAFE_F00D, 4'd0);
            set_lane(3, 64'h1357_9BDF_2468_ACE0, 4'd12);
          end
        endcase
      end
      tick(acc, ov, ir, oh);
      chk("dir_valid", {63'd0, ov}, {63'd0, (k >= 6 && k <= 10)});
      case (k)
        6:  chk("key0_hash", 64'(oh[NB-1:0]), 64'h0);
        7:  chk("key1_hash", 64'(oh[NB-1:0]), 64'h05A7);
        8:  chk("ones_len1", 64'(oh[NB-1:0]), 64'h2160);
        9:  chk("ones_len0", 64'(oh[NB-1:0]), 64'h0);
        10: chk("lane2_len0", 64'(oh[2*NB +: NB]), 64'h0);
        default: ;
      endcase
    end

    // Back-to-back 8 beats: output valid continuous from the 6th sample.
    for (int k = 1; k <= 14; k++) begin
      in_valid = (k <= 8);
      if (k <= 8) rand_beat();
      tick(acc, ov, ir, oh);
      chk("b2b_valid", {63'd0, ov}, {63'd0, (k >= 6 && k <= 13)});
    end

    // Stall for 3 clocks with beats in flight; upstream holds its beat.
    sent = 0; pending = 1'b0;
    for (int k = 1; k <= 22; k++) begin
      if (!pending && sent < 6) begin rand_beat(); pending = 1'b1; end
      in_valid  = pending;
      out_ready = !(k >= 7 && k <= 9);
      tick(acc, ov, ir, oh);
      if (k >= 7 && k <= 9) chk("stall_in_ready", {63'd0, ir}, 64'd0);
      if (acc) begin pending = 1'b0; sent++; end
    end
    chk("stall_drain", 64'(sb.size()), 64'd0);

    // Reset with beats in flight and one waiting at the output.
    out_ready = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      in_valid = (k <= 3);
      if (k <= 3) rand_beat();
      tick(acc, ov, ir, oh);
    end
    chk("pre_rst_valid", {63'd0, out_valid}, 64'd1);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("async_rst_hash", 64'(out_hash), 64'd0);
    chk("async_rst_tag", 64'(out_tag), 64'd0);
    sb.delete();
    stalled_prev = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    out_ready = 1'b1;
    n_out = 0;
    repeat (12) tick(acc, ov, ir, oh);
    chk("stale_beats", 64'(n_out), 64'd0);

    // Random soak with random backpressure.
    pending = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (!pending) begin
        if ($urandom_range(0, 3) != 0) begin rand_beat(); pending = 1'b1; end
      end
      in_valid  = pending;
      out_ready = ($urandom_range(0, 3) != 0);
      tick(acc, ov, ir, oh);
      if (acc) pending = 1'b0;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (10) tick(acc, ov, ir, oh);
    chk("soak_drain", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
